rs_deinterleaver_pp: RTL and testbench

//   Block deinterleaver for the RS link datapath; inverse of the D x N row/column block interleaver.
//   - Input: interleaved symbol stream, index j = c*D + r (c = column 0..N-1, r = row 0..D-1).
//   - Output: the same D*N symbols restored to codeword order, index r*N + c.
//   - Ping-pong buffer: one bank fills while the other drains, so throughput is one symbol per clock.
//   - Sits between the channel/interleaved stream and the RS decoder; valid/ready on both sides.

---
 rtl/rs_deinterleaver_pp.sv | 220 ++++++++++++++++++++++
 tb/tb_rs_deinterleaver_pp.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_deinterleaver_pp.sv
// rs_deinterleaver_pp
//   Ping-pong block deinterleaver for the RS link datapath (inverse of a
//   D x N row/column block interleaver). Symbols arrive column-major
//   (index c*D + r) and leave in codeword order (index r*N + c).
//   One bank fills while the other drains, so throughput is one symbol/clock.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   blk_soft_rst          synchronous active-high block resync (same as rst)
//   in_valid/in_data/in_ready      interleaved input stream
//   out_valid/out_data/out_ready   deinterleaved output stream
//   block_start           high with out_valid on symbol 0 of each block
//   blk_cnt               (only with RS_DEINTLV_BLKCNT_EN) count of output
//                         blocks whose last symbol has transferred
//
// Optional feature macro: RS_DEINTLV_BLKCNT_EN
//
// Read pipeline: bank RAM registered read (stage 1) -> output register.
// A bank is released back to EMPTY as soon as its last address has been
// read out of the RAM; the remaining symbols of that block live in the two
// pipeline registers, so the bank can be refilled immediately. This is what
// keeps in_ready high under continuous traffic.
module rs_deinterleaver_pp #(
  parameter int D = 8,
  parameter int N = 7,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_soft_rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
`ifdef RS_DEINTLV_BLKCNT_EN
  output logic [31:0]  blk_cnt,
`endif
  output logic         block_start
);

  localparam int DEPTH = D * N;
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = $clog2(D);
  localparam int CW    = $clog2(N);

  localparam logic [RW-1:0] R_LAST = RW'(D - 1);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] A_STEP = AW'(N);

  localparam logic [1:0] EMPTY    = 2'd0;
  localparam logic [1:0] FILLING  = 2'd1;
  localparam logic [1:0] FULL     = 2'd2;
  localparam logic [1:0] DRAINING = 2'd3;

  logic srst;
  assign srst = rst | blk_soft_rst;

  // ---------------- write side ----------------
  logic          wr_bank_reg;
  logic [RW-1:0] wr_row_reg;
  logic [CW-1:0] wr_col_reg;
  logic [AW-1:0] wr_addr_reg;   // always equals wr_row_reg*N + wr_col_reg
  logic          wr_accept;
  logic          wr_last;
  logic [1:0]    wr_state;

  assign in_ready  = (wr_state == EMPTY) || (wr_state == FILLING);
  assign wr_accept = in_valid & in_ready;
  assign wr_last   = (wr_row_reg == R_LAST) && (wr_col_reg == C_LAST);

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_bank_reg <= 1'b0;
      wr_row_reg  <= '0;
      wr_col_reg  <= '0;
      wr_addr_reg <= '0;
    end else if (wr_accept) begin
      if (wr_last) begin
        wr_row_reg  <= '0;
        wr_col_reg  <= '0;
        wr_addr_reg <= '0;
        wr_bank_reg <= ~wr_bank_reg;
      end else if (wr_row_reg == R_LAST) begin
        // column done: restart at row 0 of the next column
        wr_row_reg  <= '0;
        wr_col_reg  <= wr_col_reg + 1'b1;
        wr_addr_reg <= AW'(wr_col_reg) + AW'(1);
      end else begin
        wr_row_reg  <= wr_row_reg + 1'b1;
        wr_addr_reg <= wr_addr_reg + A_STEP;
      end
    end
  end

  // ---------------- read side ----------------
  logic          rd_bank_reg;
  logic [AW-1:0] rd_addr_reg;
  logic          rd_en;
  logic          rd_last;
  logic [1:0]    rd_state;

  logic          s1_valid_reg;
  logic          s1_bank_reg;
  logic          s1_first_reg;
  logic          out_valid_reg;
  logic          out_first_reg;
  logic [W-1:0]  out_data_reg;
  logic          out_load;
  logic          s1_adv;
  logic [W-1:0]  s1_data;

  // Output register may take a new symbol when empty or being consumed;
  // stage 1 may advance when empty or when it is moving into the output.
  assign out_load = ~out_valid_reg | out_ready;
  assign s1_adv   = ~s1_valid_reg | out_load;
  assign rd_en    = ((rd_state == FULL) || (rd_state == DRAINING)) && s1_adv;
  assign rd_last  = (rd_addr_reg == A_LAST);

  always_ff @(posedge clk) begin
    if (srst) begin
      rd_bank_reg <= 1'b0;
      rd_addr_reg <= '0;
    end else if (rd_en) begin
      if (rd_last) begin
        rd_addr_reg <= '0;
        rd_bank_reg <= ~rd_bank_reg;
      end else begin
        rd_addr_reg <= rd_addr_reg + 1'b1;
      end
    end
  end

  // ---------------- banks ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_q;
    logic [1:0]   state_reg;

    // RAM: no reset on contents or read register.
    always_ff @(posedge clk) begin
      if (wr_accept && (wr_bank_reg == 1'(gi)))
        mem[wr_addr_reg] <= in_data;
      if (rd_en && (rd_bank_reg == 1'(gi)))
        rd_q <= mem[rd_addr_reg];
    end

    // A bank is never written and read in the same cycle (the two sides
    // require disjoint states), so the priority order below is only a
    // formality; updates to the two banks are independent.
    always_ff @(posedge clk) begin
      if (srst)
        state_reg <= EMPTY;
      else if (rd_en && (rd_bank_reg == 1'(gi)))
        state_reg <= rd_last ? EMPTY : DRAINING;
      else if (wr_accept && (wr_bank_reg == 1'(gi)))
        state_reg <= wr_last ? FULL : FILLING;
    end
  end

  assign wr_state = wr_bank_reg ? g_bank[1].state_reg : g_bank[0].state_reg;
  assign rd_state = rd_bank_reg ? g_bank[1].state_reg : g_bank[0].state_reg;
  assign s1_data  = s1_bank_reg ? g_bank[1].rd_q : g_bank[0].rd_q;

  // Stage 1 tracks what the bank read registers currently present.
  always_ff @(posedge clk) begin
    if (srst) begin
      s1_valid_reg <= 1'b0;
      s1_bank_reg  <= 1'b0;
      s1_first_reg <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= rd_en;
      s1_bank_reg  <= rd_bank_reg;
      s1_first_reg <= (rd_addr_reg == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      out_valid_reg <= 1'b0;
      out_first_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (out_load) begin
      out_valid_reg <= s1_valid_reg;
      out_first_reg <= s1_valid_reg & s1_first_reg;
      if (s1_valid_reg)
        out_data_reg <= s1_data;
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign block_start = out_first_reg;

`ifdef RS_DEINTLV_BLKCNT_EN
  logic        s1_last_reg;
  logic        out_last_reg;
  logic [31:0] blk_cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      s1_last_reg  <= 1'b0;
      out_last_reg <= 1'b0;
      blk_cnt_reg  <= '0;
    end else begin
      if (s1_adv)
        s1_last_reg <= rd_last;
      if (out_load)
        out_last_reg <= s1_valid_reg & s1_last_reg;
      if (out_valid_reg && out_ready && out_last_reg)
        blk_cnt_reg <= blk_cnt_reg + 32'd1;
    end
  end

  assign blk_cnt = blk_cnt_reg;
`endif

endmodule

// File: tb/tb_rs_deinterleaver_pp.sv
module tb_rs_deinterleaver_pp;
  localparam int D   = 8;
  localparam int N   = 7;
  localparam int W   = 8;
  localparam int BLK = D * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_soft_rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b1;
  logic         block_start;
`ifdef RS_DEINTLV_BLKCNT_EN
  logic [31:0]  blk_cnt;
`endif

  always #5 clk = ~clk;

  rs_deinterleaver_pp #(.D(D), .N(N), .W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .blk_soft_rst (blk_soft_rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
`ifdef RS_DEINTLV_BLKCNT_EN
    .blk_cnt      (blk_cnt),
`endif
    .block_start  (block_start)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         first;
  } exp_t;

  exp_t         exp_q [$];
  logic [W-1:0] blk_buf [$];
  exp_t         e;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rdy_mode = 1;       // 0: out_ready low, 1: high, 2: random
  int n_out    = 0;
  int n_start  = 0;
  int n_acc    = 0;
  int last_acc_cyc    = 0;
  int first_valid_cyc = -1;
  int first_out_cyc   = -1;
  int last_out_cyc    = 0;
  int ir_drop         = 0;
  bit track_ir        = 1'b0;
  bit prev_stall      = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_start;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: input bookkeeping, scoreboard push/pop, stall stability.
  always @(negedge clk) begin
    if (rst || blk_soft_rst) begin
      prev_stall = 1'b0;
      blk_buf.delete();
      exp_q.delete();
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_start", 32'(block_start), 32'(prev_start));
      end
      if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_block_start", 32'(block_start), 32'(e.first));
        end
        n_out++;
        if (block_start === 1'b1) n_start++;
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
      end
      prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev_data  = out_data;
      prev_start = block_start;
      if (track_ir && in_valid === 1'b1 && in_ready !== 1'b1) ir_drop++;
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        blk_buf.push_back(in_data);
        n_acc++;
        last_acc_cyc = cyc;
        if (blk_buf.size() == BLK) begin
          // output k = (row k/N, col k%N) arrived at input index col*D + row
          for (int k = 0; k < BLK; k++) begin
            e.data  = blk_buf[(k % N) * D + k / N];
            e.first = (k == 0);
            exp_q.push_back(e);
          end
          blk_buf.delete();
        end
      end
    end
  end

  task automatic send_sym(input logic [W-1:0] v, input int limit, output bit ok);
    int t = 0;
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < limit) begin
      @(negedge clk);
      t++;
    end
    ok = (in_ready === 1'b1);
    if (ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: value r*N+c at input index c*D+r; otherwise random data
  task automatic send_block(input int mode);
    bit ok;
    for (int j = 0; j < BLK; j++) begin
      send_sym((mode == 0) ? W'((j % D) * N + j / D) : W'($urandom), 400, ok);
      if (!ok) begin
        chk("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int t = 0;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  int base_out, base_start, base_acc;
  logic [W-1:0] vals [BLK];
  bit ok;
`ifdef RS_DEINTLV_BLKCNT_EN
  logic [31:0] base_cnt;
`endif

  initial begin
    rst = 1'b1; blk_soft_rst = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_block_start", 32'(block_start), 32'd0);
`ifdef RS_DEINTLV_BLKCNT_EN
    chk("rst_blk_cnt", blk_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: single block, values r*N+c -> 0..55, latency check
    first_valid_cyc = -1;
    base_out = n_out; base_start = n_start;
    send_block(0);
    wait_drain(500);
    chk("t1_latency", 32'(first_valid_cyc - last_acc_cyc), 32'd3);
    chk("t1_count", 32'(n_out - base_out), 32'd56);
    chk("t1_starts", 32'(n_start - base_start), 32'd1);

    // T2: four back-to-back blocks, continuous in_valid / out_ready
`ifdef RS_DEINTLV_BLKCNT_EN
    base_cnt = blk_cnt;
`endif
    base_out = n_out; base_start = n_start;
    first_out_cyc = -1; ir_drop = 0; track_ir = 1'b1;
    for (int b = 0; b < 4; b++) send_block(1);
    track_ir = 1'b0;
    wait_drain(1000);
    chk("t2_count", 32'(n_out - base_out), 32'd224);
    chk("t2_starts", 32'(n_start - base_start), 32'd4);
    chk("t2_in_ready_drops", 32'(ir_drop), 32'd0);
    chk("t2_gapless_span", 32'(last_out_cyc - first_out_cyc), 32'd223);
`ifdef RS_DEINTLV_BLKCNT_EN
    chk("t6_blk_cnt_after_t2", blk_cnt - base_cnt, 32'd4);
`endif

    // T3: random out_ready over four blocks
    rdy_mode = 2;
    base_out = n_out; base_start = n_start;
    for (int b = 0; b < 4; b++) send_block(1);
    wait_drain(3000);
    chk("t3_count", 32'(n_out - base_out), 32'd224);
    chk("t3_starts", 32'(n_start - base_start), 32'd4);

    // T4: out_ready held low, three blocks offered
    rdy_mode = 0;
    @(posedge clk); #1;
    base_out = n_out; base_acc = n_acc;
    send_block(1);
    send_block(1);
    for (int j = 0; j < BLK; j++) vals[j] = W'($urandom);
    send_sym(vals[0], 20, ok);
    chk("t4_third_blocked", 32'(ok), 32'd0);
    chk("t4_accepts", 32'(n_acc - base_acc), 32'd112);
    chk("t4_in_ready_low", 32'(in_ready), 32'd0);
    rdy_mode = 1;
    for (int j = 0; j < BLK; j++) begin
      send_sym(vals[j], 400, ok);
      if (!ok) begin
        chk("t4_resume_timeout", 32'd0, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
    wait_drain(1000);
    chk("t4_count", 32'(n_out - base_out), 32'd168);

    // T5: soft reset after 20 input symbols
    for (int j = 0; j < 20; j++) send_sym(W'($urandom), 400, ok);
    in_valid = 1'b0;
    blk_soft_rst = 1'b1;
    @(posedge clk); #1;
    blk_soft_rst = 1'b0;
    @(negedge clk);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    base_out = n_out;
    send_block(0);
    wait_drain(500);
    chk("t5_count", 32'(n_out - base_out), 32'd56);

    // Reset mid-drain drops the in-flight symbol
    rdy_mode = 0;
    send_block(1);
    for (int t = 0; t < 20 && out_valid !== 1'b1; t++) @(posedge clk);
    #1;
    chk("mid_drain_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_block_start", 32'(block_start), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef RS_DEINTLV_BLKCNT_EN
    chk("t6_blk_cnt_rst", blk_cnt, 32'd0);
`endif
    repeat (5) @(negedge clk);
    chk("mid_rst_no_output", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    base_out = n_out;
    send_block(0);
    wait_drain(500);
    chk("post_rst_count", 32'(n_out - base_out), 32'd56);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
